// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the fault-tolerance recovery writer.
package ft_pkg;
  typedef enum logic [2:0] {IDLE, HALT, READ, DRAIN, SETPC, RESUME} rw_state_e;
  localparam int RCNT_WIDTH = 8;
  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/ft_recovery_writer.sv
// ft_recovery_writer: halts both lockstep cores, restores GPRs 1..NREGS-1 and PC from shadow state, then resumes.
module ft_recovery_writer
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int HALT_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic                  halted_a_i,
  input  logic                  halted_b_i,
  output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
  input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
  input  logic [DATA_WIDTH-1:0] spc_i,
  output logic                  halt_req_o,
  output logic                  fetch_block_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  pc_set_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  done_o,
  output logic                  fatal_o,
  output logic [RCNT_WIDTH-1:0] recovery_cnt_o
);
  localparam int NREGS = nregs(ADDR_WIDTH);
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  rw_state_e state, nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0] wait_cnt;
  logic pending, acks, timeout;
  assign acks = halted_a_i & halted_b_i;
  assign timeout = state == HALT && !fatal_o && !acks && wait_cnt == TW'(HALT_TIMEOUT - 1);
  assign halt_req_o = state inside {HALT, READ, DRAIN, SETPC};
  assign fetch_block_o = halt_req_o;
  assign pc_set_o = state == SETPC;
  assign done_o = state == RESUME;
  assign sgpr_raddr_o = state == READ ? addr : '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = error_i ? HALT : IDLE;
      HALT:    nxt = (!fatal_o && acks) ? READ : HALT;
      READ:    nxt = addr == ADDR_WIDTH'(NREGS - 1) ? DRAIN : READ;
      DRAIN:   nxt = SETPC;
      SETPC:   nxt = RESUME;
      RESUME:  nxt = (pending || error_i) ? HALT : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Write stage trails the zero-latency sgpr read by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      addr           <= '0;
      wait_cnt       <= '0;
      pending        <= 1'b0;
      fatal_o        <= 1'b0;
      rf_we_o        <= 1'b0;
      rf_waddr_o     <= '0;
      rf_wdata_o     <= '0;
      pc_o           <= '0;
      recovery_cnt_o <= '0;
    end else begin
      state          <= nxt;
      addr           <= state == READ ? addr + 1'b1 : ADDR_WIDTH'(1);
      wait_cnt       <= (state == HALT && !acks && !fatal_o) ? wait_cnt + 1'b1 : '0;
      pending        <= state == RESUME ? 1'b0 : pending | (error_i && state != IDLE);
      fatal_o        <= fatal_o | timeout;
      rf_we_o        <= state == READ;
      rf_waddr_o     <= state == READ ? addr : '0;
      rf_wdata_o     <= state == READ ? sgpr_rdata_i : '0;
      pc_o           <= state == DRAIN ? spc_i : '0;
      recovery_cnt_o <= (state == SETPC && recovery_cnt_o != '1) ? recovery_cnt_o + 1'b1 : recovery_cnt_o;
    end
  end
endmodule

// File: tb/tb_ft_recovery_writer.sv
// tb_ft_recovery_writer: scoreboard bench for ft_recovery_writer with directed recovery scenarios.
module tb_ft_recovery_writer;
  typedef struct {int c; logic [4:0] a; logic [31:0] d;} wr_t;
  typedef struct {int c; logic [31:0] v;} pc_t;
  typedef struct {int c; int n;} dn_t;
  logic clk = 0, rst_i = 1, error_i = 0, halted_a_i = 0, halted_b_i = 0;
  logic [4:0] sgpr_raddr_o, rf_waddr_o;
  logic [31:0] sgpr_rdata_i, spc_i = 32'h0000_1F00, rf_wdata_o, pc_o;
  logic halt_req_o, fetch_block_o, rf_we_o, pc_set_o, done_o, fatal_o;
  logic [7:0] recovery_cnt_o;
  logic [31:0] mem [32];
  wr_t wq[$];
  pc_t pq[$];
  dn_t dq[$];
  int cyc = 0, checks = 0, errors = 0, exp_cnt = 0;

  ft_recovery_writer dut (
    .clk_i(clk), .rst_i(rst_i), .error_i(error_i), .halted_a_i(halted_a_i), .halted_b_i(halted_b_i),
    .sgpr_raddr_o(sgpr_raddr_o), .sgpr_rdata_i(sgpr_rdata_i), .spc_i(spc_i),
    .halt_req_o(halt_req_o), .fetch_block_o(fetch_block_o), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .pc_set_o(pc_set_o), .pc_o(pc_o),
    .done_o(done_o), .fatal_o(fatal_o), .recovery_cnt_o(recovery_cnt_o)
  );

  assign sgpr_rdata_i = mem[sgpr_raddr_o];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    wr_t w;
    pc_t p;
    dn_t d;
    if (rf_we_o) begin
      if (wq.size() == 0) unexpected("write");
      else begin
        w = wq.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(w.c));
        chk("wr_addr", 64'(rf_waddr_o), 64'(w.a));
        chk("wr_data", 64'(rf_wdata_o), 64'(w.d));
      end
    end
    if (pc_set_o) begin
      if (pq.size() == 0) unexpected("pc_set");
      else begin
        p = pq.pop_front();
        chk("pc_cycle", 64'(cyc), 64'(p.c));
        chk("pc_value", 64'(pc_o), 64'(p.v));
      end
    end
    if (done_o) begin
      if (dq.size() == 0) unexpected("done");
      else begin
        d = dq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(d.c));
        chk("recovery_cnt", 64'(recovery_cnt_o), 64'(d.n));
      end
    end
  end

  task automatic push_rec(input int h, input logic [31:0] pc, input int n, input int nwr);
    for (int i = 1; i <= nwr; i++) wq.push_back('{h + 1 + i, 5'(i), mem[i]});
    if (nwr == 31) begin
      pq.push_back('{h + 33, pc});
      dq.push_back('{h + 34, n});
    end
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  task automatic wait_empty(input int bound);
    int k = 0;
    while ((wq.size() + pq.size() + dq.size()) != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("queues_drained", 64'(wq.size() + pq.size() + dq.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_halt_req"}, 64'(halt_req_o), 64'd0);
    chk({tag, "_fetch_block"}, 64'(fetch_block_o), 64'd0);
    chk({tag, "_rf_we"}, 64'(rf_we_o), 64'd0);
    chk({tag, "_rf_waddr"}, 64'(rf_waddr_o), 64'd0);
    chk({tag, "_rf_wdata"}, 64'(rf_wdata_o), 64'd0);
    chk({tag, "_sgpr_raddr"}, 64'(sgpr_raddr_o), 64'd0);
    chk({tag, "_pc_set"}, 64'(pc_set_o), 64'd0);
    chk({tag, "_pc"}, 64'(pc_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_fatal"}, 64'(fatal_o), 64'd0);
    chk({tag, "_recovery_cnt"}, 64'(recovery_cnt_o), 64'd0);
  endtask

  task automatic simple_rec();
    int c;
    @(negedge clk);
    c = cyc;
    exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
    push_rec(c + 1, spc_i, exp_cnt, 31);
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    wait_empty(100);
  endtask

  initial begin
    int c, n;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_i = 0;
    @(negedge clk);
    chk_zero("idle");
    // single recovery, cores already halted
    halted_a_i = 1;
    halted_b_i = 1;
    simple_rec();
    chk("after_rec_fetch_block", 64'(fetch_block_o), 64'd0);
    // delayed acknowledge: B follows A by 5 cycles
    halted_a_i = 0;
    halted_b_i = 0;
    spc_i = 32'h2000_0040;
    @(negedge clk);
    c = cyc;
    exp_cnt++;
    push_rec(c + 8, spc_i, exp_cnt, 31);
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    wait_cyc(c + 3);
    halted_a_i = 1;
    wait_cyc(c + 8);
    halted_b_i = 1;
    wait_empty(100);
    // error during READ and during RESUME: exactly one back-to-back recovery
    @(negedge clk);
    c = cyc;
    push_rec(c + 1, spc_i, exp_cnt + 1, 31);
    push_rec(c + 36, spc_i, exp_cnt + 2, 31);
    exp_cnt += 2;
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    wait_cyc(c + 10);
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    wait_cyc(c + 35);
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    wait_empty(150);
    repeat (50) @(negedge clk);
    chk("no_third_rec_halt", 64'(halt_req_o), 64'd0);
    // reset at the 10th write, with a simultaneous error
    @(negedge clk);
    c = cyc;
    push_rec(c + 1, spc_i, 0, 10);
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    wait_cyc(c + 12);
    rst_i = 1;
    error_i = 1;
    @(negedge clk);
    rst_i = 0;
    error_i = 0;
    chk_zero("abort");
    chk("abort_flush", 64'(wq.size()), 64'd0);
    @(negedge clk);
    chk("reset_wins_halt", 64'(halt_req_o), 64'd0);
    exp_cnt = 0;
    simple_rec();
    // saturation
    for (int r = 0; r < 256; r++) simple_rec();
    chk("saturated_cnt", 64'(recovery_cnt_o), 64'd255);
    // acknowledge never arrives
    rst_i = 1;
    halted_a_i = 0;
    halted_b_i = 0;
    @(negedge clk);
    rst_i = 0;
    error_i = 1;
    @(negedge clk);
    error_i = 0;
    n = 0;
    for (int k = 0; k < 200 && !fatal_o; k++) begin
      if (halt_req_o) n++;
      @(negedge clk);
    end
    chk("fatal_set", 64'(fatal_o), 64'd1);
    chk("halt_cycles_to_fatal", 64'(n), 64'd64);
    halted_a_i = 1;
    halted_b_i = 1;
    repeat (10) @(negedge clk);
    chk("fatal_sticky", 64'(fatal_o), 64'd1);
    chk("fatal_fetch_block", 64'(fetch_block_o), 64'd1);
    chk("fatal_halt_req", 64'(halt_req_o), 64'd1);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk_zero("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
